// File: rtl/mipi_tx_lane_framer.sv
// Single-lane MIPI D-PHY transmit framer: wraps an LSB-first byte stream in a
// complete HS burst (LP-11, LP-01, LP-00, HS-zero, SoT 0xB8, payload, trail, LP-11).
module mipi_tx_lane_framer #(
    parameter int T_LPX        = 4,
    parameter int T_HS_PREPARE = 3,
    parameter int T_HS_ZERO    = 6,
    parameter int T_HS_TRAIL   = 5,
    parameter int T_HS_EXIT    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] hs_dout,
    output logic       hs_oe,
    output logic       lp_dp,
    output logic       lp_dn,
    output logic       busy,
    output logic       underflow
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RQST  = 3'd1,
        ST_PREP  = 3'd2,
        ST_ZERO  = 3'd3,
        ST_SYNC  = 3'd4,
        ST_DATA  = 3'd5,
        ST_TRAIL = 3'd6,
        ST_EXIT  = 3'd7
    } state_t;

    localparam logic [7:0] SOT_BYTE = 8'hB8;

    state_t     state_r;
    state_t     state_s;
    logic [7:0] cnt_r;
    logic [7:0] data_r;
    logic       last_r;
    logic       underflow_r;
    logic       hs_phase_s;
    logic       take_s;

    // Each timed state runs PARAM cycles: counter starts at PARAM-1 and exits at 0.
    function automatic logic [7:0] load_cnt(input state_t st);
        case (st)
            ST_RQST:  return 8'(T_LPX - 1);
            ST_PREP:  return 8'(T_HS_PREPARE - 1);
            ST_ZERO:  return 8'(T_HS_ZERO - 1);
            ST_TRAIL: return 8'(T_HS_TRAIL - 1);
            ST_EXIT:  return 8'(T_HS_EXIT - 1);
            default:  return 8'h00;
        endcase
    endfunction

    // Handshake window: SYNC/DATA, except the final DATA cycle that only presents s_last's byte.
    always_comb begin
        hs_phase_s = 1'b0;
        if ((state_r == ST_SYNC) || (state_r == ST_DATA)) begin
            hs_phase_s = ~last_r;
        end else begin
            hs_phase_s = 1'b0;
        end
        take_s = hs_phase_s & s_valid;
    end

    // State, counter, payload register and underflow pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 8'h00;
            data_r      <= 8'h00;
            last_r      <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if (state_s != state_r) begin
                cnt_r <= load_cnt(state_s);
            end else if (cnt_r != 8'h00) begin
                cnt_r <= cnt_r - 8'd1;
            end
            if ((state_s == ST_SYNC) && (state_r != ST_SYNC)) begin
                data_r <= SOT_BYTE;
            end else if (take_s) begin
                data_r <= s_data;
            end
            last_r      <= take_s & s_last;
            underflow_r <= hs_phase_s & ~s_valid;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  state_s = s_valid ? ST_RQST : ST_IDLE;
            ST_RQST:  state_s = (cnt_r == 8'h00) ? ST_PREP : ST_RQST;
            ST_PREP:  state_s = (cnt_r == 8'h00) ? ST_ZERO : ST_PREP;
            ST_ZERO:  state_s = (cnt_r == 8'h00) ? ST_SYNC : ST_ZERO;
            ST_SYNC,
            ST_DATA: begin
                if (last_r) begin
                    state_s = ST_TRAIL;
                end else if (s_valid) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_TRAIL;
                end
            end
            ST_TRAIL: state_s = (cnt_r == 8'h00) ? ST_EXIT : ST_TRAIL;
            ST_EXIT:  state_s = (cnt_r == 8'h00) ? ST_IDLE : ST_EXIT;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Output decode from registered state only.
    always_comb begin
        lp_dp   = 1'b1;
        lp_dn   = 1'b1;
        hs_oe   = 1'b0;
        hs_dout = 8'h00;
        case (state_r)
            ST_IDLE: begin
                lp_dp = 1'b1;
                lp_dn = 1'b1;
            end
            ST_RQST: begin
                lp_dp = 1'b0;
                lp_dn = 1'b1;
            end
            ST_PREP: begin
                lp_dp = 1'b0;
                lp_dn = 1'b0;
            end
            ST_ZERO: begin
                lp_dp = 1'b0;
                lp_dn = 1'b0;
                hs_oe = 1'b1;
            end
            ST_SYNC: begin
                lp_dp   = 1'b0;
                lp_dn   = 1'b0;
                hs_oe   = 1'b1;
                hs_dout = SOT_BYTE;
            end
            ST_DATA: begin
                lp_dp   = 1'b0;
                lp_dn   = 1'b0;
                hs_oe   = 1'b1;
                hs_dout = data_r;
            end
            // Trail holds the complement of the last serialized bit (MSB of the last byte).
            ST_TRAIL: begin
                lp_dp   = 1'b0;
                lp_dn   = 1'b0;
                hs_oe   = 1'b1;
                hs_dout = data_r[7] ? 8'h00 : 8'hFF;
            end
            ST_EXIT: begin
                lp_dp = 1'b1;
                lp_dn = 1'b1;
            end
            default: begin
                lp_dp = 1'b1;
                lp_dn = 1'b1;
            end
        endcase
        s_ready   = hs_phase_s;
        busy      = (state_r != ST_IDLE);
        underflow = underflow_r;
    end

endmodule

// File: tb/tb_mipi_tx_lane_framer.sv
// Directed bench for mipi_tx_lane_framer: per-cycle lane traces against hand-built expectations.
module tb_mipi_tx_lane_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic [7:0] hs_dout;
    logic       hs_oe;
    logic       lp_dp;
    logic       lp_dn;
    logic       busy;
    logic       underflow;

    int tests  = 0;
    int failed = 0;

    logic [7:0]  pay [0:7];
    logic [13:0] tr  [0:63];
    logic [13:0] ex  [0:63];

    mipi_tx_lane_framer dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .hs_dout(hs_dout), .hs_oe(hs_oe), .lp_dp(lp_dp), .lp_dn(lp_dn),
        .busy(busy), .underflow(underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Record layout: {lp_dp, lp_dn, hs_oe, hs_dout, s_ready, busy, underflow}
    function automatic logic [13:0] rec(input logic [1:0] lp, input logic oe, input logic [7:0] d,
                                        input logic rdy, input logic bsy, input logic uf);
        return {lp, oe, d, rdy, bsy, uf};
    endfunction

    function automatic logic [13:0] obs();
        return {lp_dp, lp_dn, hs_oe, hs_dout, s_ready, busy, underflow};
    endfunction

    // Expected RQST x4, PREP x3, ZERO x6, SYNC for default timing.
    task automatic exp_prefix();
        for (int i = 0; i < 4; i++)  ex[i] = rec(2'b01, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 4; i < 7; i++)  ex[i] = rec(2'b00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 7; i < 13; i++) ex[i] = rec(2'b00, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        ex[13] = rec(2'b00, 1'b1, 8'hB8, 1'b1, 1'b1, 1'b0);
    endtask

    // Expected TRAIL x5, EXIT x4, then one IDLE cycle.
    task automatic exp_tail(input int st, input logic [7:0] tb, input logic uf);
        for (int i = 0; i < 5; i++)
            ex[st+i] = rec(2'b00, 1'b1, tb, 1'b0, 1'b1, (i == 0) ? uf : 1'b0);
        for (int i = 0; i < 4; i++)
            ex[st+5+i] = rec(2'b11, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        ex[st+9] = rec(2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    // Drive a burst from IDLE and record ncyc cycles, starting with the first RQST cycle.
    task automatic capture(input int ncyc, input int n, input logic drop, input logic hold);
        int   idx;
        logic hs;
        idx     = 0;
        s_valid = 1'b1;
        s_data  = pay[0];
        s_last  = (n == 1) && !drop;
        for (int c = 0; c < ncyc; c++) begin
            hs = s_valid && s_ready;
            @(posedge clk); #1;
            if (hs) idx++;
            if (idx < n) begin
                s_valid = 1'b1;
                s_data  = pay[idx];
                s_last  = (idx == n - 1) && !drop;
            end else begin
                s_valid = hold;
                s_data  = 8'h00;
                s_last  = 1'b0;
            end
            tr[c] = obs();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (obs() !== rec(2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0)) begin
            failed++;
            $display("FAIL reset_values got %h exp %h", obs(), rec(2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        end
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            tests++;
            if (obs() !== rec(2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0)) begin
                failed++;
                $display("FAIL idle_hold cyc %0d got %h exp %h", c, obs(), rec(2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
            end
        end
    endtask

    task automatic test_burst();
        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
        exp_prefix();
        ex[14] = rec(2'b00, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0);
        ex[15] = rec(2'b00, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0);
        ex[16] = rec(2'b00, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0);
        exp_tail(17, 8'hFF, 1'b0);
        capture(27, 3, 1'b0, 1'b0);
        for (int c = 0; c < 27; c++) begin
            tests++;
            if (tr[c] !== ex[c]) begin
                failed++;
                $display("FAIL burst3 cyc %0d got %h exp %h", c, tr[c], ex[c]);
            end
        end
    endtask

    task automatic test_one_byte();
        pay[0] = 8'h80;
        exp_prefix();
        ex[14] = rec(2'b00, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0);
        exp_tail(15, 8'h00, 1'b0);
        capture(25, 1, 1'b0, 1'b0);
        for (int c = 0; c < 25; c++) begin
            tests++;
            if (tr[c] !== ex[c]) begin
                failed++;
                $display("FAIL one_byte cyc %0d got %h exp %h", c, tr[c], ex[c]);
            end
        end
    endtask

    task automatic test_underflow();
        pay[0] = 8'h11; pay[1] = 8'h22;
        exp_prefix();
        ex[14] = rec(2'b00, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0);
        ex[15] = rec(2'b00, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0);
        exp_tail(16, 8'hFF, 1'b1);
        capture(26, 2, 1'b1, 1'b0);
        for (int c = 0; c < 26; c++) begin
            tests++;
            if (tr[c] !== ex[c]) begin
                failed++;
                $display("FAIL underflow cyc %0d got %h exp %h", c, tr[c], ex[c]);
            end
        end
    endtask

    // Abort after k edges from IDLE; the cycle before reset must show hs_oe=1 with byte d.
    task automatic test_reset_mid(input int k, input logic [7:0] d);
        s_valid = 1'b1; s_data = 8'h01; s_last = 1'b0;
        repeat (k) @(posedge clk);
        #1;
        tests++;
        if ({lp_dp, lp_dn, hs_oe, hs_dout} !== {2'b00, 1'b1, d}) begin
            failed++;
            $display("FAIL pre_abort k=%0d got %h exp %h", k, {lp_dp, lp_dn, hs_oe, hs_dout}, {2'b00, 1'b1, d});
        end
        rst = 1'b1; s_valid = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (obs() !== rec(2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0)) begin
            failed++;
            $display("FAIL abort k=%0d got %h exp %h", k, obs(), rec(2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        end
        rst = 1'b0;
        @(posedge clk); #1;
        test_burst();
    endtask

    task automatic test_back_to_back();
        pay[0] = 8'h80;
        exp_prefix();
        ex[14] = rec(2'b00, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0);
        exp_tail(15, 8'h00, 1'b0);
        ex[25] = rec(2'b01, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        capture(26, 1, 1'b0, 1'b1);
        for (int c = 0; c < 26; c++) begin
            tests++;
            if (tr[c] !== ex[c]) begin
                failed++;
                $display("FAIL back_to_back cyc %0d got %h exp %h", c, tr[c], ex[c]);
            end
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
        @(posedge clk); #1;
        test_reset();
        test_burst();
        test_one_byte();
        test_underflow();
        test_one_byte();
        test_reset_mid(9, 8'h00);
        test_reset_mid(16, 8'h01);
        test_back_to_back();
        test_burst();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
